// File: rtl/mem_access_unit.sv
// Load/store initiator for the byte-addressed data RAM: checks the request, sequences the
// one-cycle registered RAM read, extends load data and returns a single response pulse.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 499
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        stall,
    output logic [31:0] ram_data_address,
    output logic [31:0] ram_write_data,
    output logic        ram_write_enable,
    output logic        ram_write_byte_enable,
    output logic        ram_write_half_word_enable,
    input  logic [31:0] ram_read_data
);

    typedef enum logic [2:0] {
        StIdle,
        StStWr,
        StLdAddr,
        StLdData,
        StResp
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_is_store;
    logic [31:0] r_rdata;
    logic        r_fault;

    logic        w_accept;
    logic        w_legal;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_fault;
    logic [2:0]  w_size_m1;
    logic [32:0] w_last_byte;
    logic [31:0] w_ld_data;

    assign req_ready = reset_n && (r_state == StIdle);
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !req_is_store;
            default:                w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_size_m1 = 3'd3;
        case (req_funct3[1:0])
            2'b00:   w_size_m1 = 3'd0;
            2'b01:   w_size_m1 = 3'd1;
            default: w_size_m1 = 3'd3;
        endcase
    end

    assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    // 33-bit sum so an address near 0xFFFFFFFF cannot wrap back into range
    assign w_last_byte    = {1'b0, req_addr} + {30'd0, w_size_m1};
    assign w_out_of_range = w_last_byte >= 33'(MEM_BYTES);
    assign w_fault        = !w_legal || w_misaligned || w_out_of_range;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_fault) begin
                        w_state_next = StResp;
                    end else if (req_is_store) begin
                        w_state_next = StStWr;
                    end else begin
                        w_state_next = StLdAddr;
                    end
                end
            end
            StStWr:   w_state_next = StResp;
            StLdAddr: w_state_next = StLdData;
            StLdData: w_state_next = StResp;
            StResp:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_ld_data = ram_read_data;
        case (r_funct3)
            3'b000:  w_ld_data = {{24{ram_read_data[7]}}, ram_read_data[7:0]};
            3'b001:  w_ld_data = {{16{ram_read_data[15]}}, ram_read_data[15:0]};
            3'b100:  w_ld_data = {24'd0, ram_read_data[7:0]};
            3'b101:  w_ld_data = {16'd0, ram_read_data[15:0]};
            default: w_ld_data = ram_read_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_funct3   <= 3'd0;
            r_is_store <= 1'b0;
            r_rdata    <= 32'd0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_funct3   <= req_funct3;
                r_is_store <= req_is_store;
            end
            // Response registers change only on the edge that enters the response cycle
            if (w_accept && w_fault) begin
                r_rdata <= 32'd0;
                r_fault <= 1'b1;
            end else if (r_state == StStWr) begin
                r_rdata <= 32'd0;
                r_fault <= 1'b0;
            end else if (r_state == StLdData) begin
                r_rdata <= w_ld_data;
                r_fault <= 1'b0;
            end
        end
    end

    assign resp_valid = reset_n && (r_state == StResp);
    assign resp_rdata = r_rdata;
    assign resp_fault = r_fault;
    assign stall      = reset_n && ((r_state != StIdle) || w_accept);

    // Every RAM control is forced low while reset_n is low, so a mid-store reset never writes
    always_comb begin
        ram_data_address           = 32'd0;
        ram_write_data             = 32'd0;
        ram_write_enable           = 1'b0;
        ram_write_byte_enable      = 1'b0;
        ram_write_half_word_enable = 1'b0;
        if (reset_n) begin
            case (r_state)
                StStWr: begin
                    ram_data_address           = r_addr;
                    ram_write_data             = r_wdata;
                    ram_write_enable           = r_is_store;
                    ram_write_byte_enable      = (r_funct3[1:0] == 2'b00);
                    ram_write_half_word_enable = (r_funct3[1:0] == 2'b01);
                end
                StLdAddr, StLdData: begin
                    ram_data_address = r_addr;
                end
                default: begin
                    ram_data_address = 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and random load/store traffic against a byte-array RAM, checked with a byte-level
// reference memory and the access rules (alignment, range, funct3 legality, latency).
module tb_mem_access_unit;

    localparam int unsigned MemBytes = 499;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        stall;
    logic [31:0] ram_data_address;
    logic [31:0] ram_write_data;
    logic        ram_write_enable;
    logic        ram_write_byte_enable;
    logic        ram_write_half_word_enable;
    logic [31:0] ram_rd = 32'd0;

    int checks = 0;
    int failures = 0;

    logic [7:0]  ram [MemBytes];
    logic [7:0]  ref_mem [MemBytes];
    logic        fill_en = 1'b0;
    logic [63:0] wa;

    mem_access_unit #(.MEM_BYTES(MemBytes)) dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .req_valid                  (req_valid),
        .req_ready                  (req_ready),
        .req_is_store               (req_is_store),
        .req_funct3                 (req_funct3),
        .req_addr                   (req_addr),
        .req_wdata                  (req_wdata),
        .resp_valid                 (resp_valid),
        .resp_rdata                 (resp_rdata),
        .resp_fault                 (resp_fault),
        .stall                      (stall),
        .ram_data_address           (ram_data_address),
        .ram_write_data             (ram_write_data),
        .ram_write_enable           (ram_write_enable),
        .ram_write_byte_enable      (ram_write_byte_enable),
        .ram_write_half_word_enable (ram_write_half_word_enable),
        .ram_read_data              (ram_rd)
    );

    always #5 clk = ~clk;

    assign wa = {32'd0, ram_data_address};

    function automatic logic [7:0] rbyte(input logic [63:0] a);
        if (a < 64'(MemBytes)) return ram[a[8:0]];
        return 8'h00;
    endfunction

    // RAM device: synchronous write, registered little-endian word read at any byte address
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < MemBytes; i++) ram[i] <= ref_mem[i];
        end else if (ram_write_enable) begin
            if (wa < 64'(MemBytes)) ram[wa[8:0]] <= ram_write_data[7:0];
            if (!ram_write_byte_enable && (wa + 64'd1 < 64'(MemBytes)))
                ram[9'(wa + 64'd1)] <= ram_write_data[15:8];
            if (!ram_write_byte_enable && !ram_write_half_word_enable) begin
                if (wa + 64'd2 < 64'(MemBytes)) ram[9'(wa + 64'd2)] <= ram_write_data[23:16];
                if (wa + 64'd3 < 64'(MemBytes)) ram[9'(wa + 64'd3)] <= ram_write_data[31:24];
            end
        end
        ram_rd <= {rbyte(wa + 64'd3), rbyte(wa + 64'd2), rbyte(wa + 64'd1), rbyte(wa)};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        int unsigned sz;
        longint unsigned end_excl;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                (!st && ((f3 == 3'd4) || (f3 == 3'd5)));
        if (!legal) return 1'b1;
        sz = size_of(f3);
        if ((a % sz) != 0) return 1'b1;
        end_excl = longint'({32'd0, a}) + longint'(sz);
        return end_excl > longint'(MemBytes);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int unsigned sz;
        sz = size_of(f3);
        v = 32'd0;
        for (int i = 0; i < sz; i++) v = v + ({24'd0, ref_mem[9'(a + 32'(i))]} << (8 * i));
        if (!f3[2] && sz < 4 && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] t;
        for (int i = 0; i < size_of(f3); i++) begin
            t = wd >> (8 * i);
            ref_mem[9'(a + 32'(i))] = t[7:0];
        end
    endtask

    task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd_o);
        bit          exp_f;
        int          exp_lat;
        logic [31:0] exp_rd;
        int          lat;
        int          we_cnt;
        bit          got;
        exp_f   = model_fault(st, f3, a);
        exp_lat = exp_f ? 1 : (st ? 2 : 3);
        exp_rd  = (exp_f || st) ? 32'd0 : model_load(f3, a);
        lat     = 0;
        we_cnt  = 0;
        got     = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        #1;
        chk("ready_in_idle", req_ready, 1);
        chk("stall_on_accept", stall, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("stall_busy", stall, 1);
            if (ram_write_enable) begin
                we_cnt++;
                chk("wr_addr", ram_data_address, a);
                chk("wr_data", ram_write_data, wd);
                chk("wr_byte_sel", ram_write_byte_enable, (size_of(f3) == 1) ? 1 : 0);
                chk("wr_half_sel", ram_write_half_word_enable, (size_of(f3) == 2) ? 1 : 0);
            end
            if (!st && !exp_f && c < 3) chk("ld_addr", ram_data_address, a);
            if (resp_valid) begin
                got = 1'b1;
                lat = c;
                chk("resp_rdata", resp_rdata, exp_rd);
                chk("resp_fault", resp_fault, exp_f ? 1 : 0);
                chk("resp_addr_zero", ram_data_address, 0);
                break;
            end
        end
        chk("latency", lat, exp_lat);
        chk("we_cycles", we_cnt, (st && !exp_f) ? 1 : 0);
        rd_o = resp_rdata;
        @(negedge clk);
        chk("resp_single_pulse", resp_valid, 0);
        chk("rdata_held", resp_rdata, exp_rd);
        chk("idle_no_stall", stall, 0);
        chk("idle_addr_zero", ram_data_address, 0);
        if (st && !exp_f) model_store(f3, a, wd);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [7:0]  old;
        int          mism;
        bit          st;
        logic [31:0] a;

        for (int i = 0; i < MemBytes; i++) ref_mem[i] = 8'($urandom);

        // Reset with a request pending: nothing may be accepted or driven to the RAM
        fill_en = 1'b1; req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 fill_en = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_stall", stall, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_fault", resp_fault, 0);
        chk("rst_we", ram_write_enable, 0);
        chk("rst_addr", ram_data_address, 0);
        chk("rst_wdata", ram_write_data, 0);
        chk("rst_byte_sel", ram_write_byte_enable, 0);
        chk("rst_half_sel", ram_write_half_word_enable, 0);
        req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd);
        do_req(1'b1, 3'b000, 32'h21, 32'h0000_0080, rd);
        do_req(1'b0, 3'b000, 32'h21, 32'd0, rd);
        chk("lb_0x21", rd, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h21, 32'd0, rd);
        chk("lbu_0x21", rd, 32'h0000_0080);
        do_req(1'b1, 3'b000, 32'h30, 32'h0000_0034, rd);
        do_req(1'b1, 3'b000, 32'h31, 32'h0000_0092, rd);
        do_req(1'b0, 3'b001, 32'h30, 32'd0, rd);
        chk("lh_0x30", rd, 32'hFFFF_9234);
        do_req(1'b1, 3'b001, 32'h30, 32'h1234_ABCD, rd);
        do_req(1'b0, 3'b101, 32'h30, 32'd0, rd);
        chk("lhu_0x30", rd, 32'h0000_ABCD);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, rd);
        chk("lw_0x10", rd, 32'hDEAD_BEEF);

        // Faults
        do_req(1'b0, 3'b010, 32'h13, 32'd0, rd);
        do_req(1'b1, 3'b001, 32'h31, 32'h5555, rd);
        do_req(1'b1, 3'b010, 32'h1F0, 32'h1111_2222, rd);
        do_req(1'b0, 3'b011, 32'h20, 32'd0, rd);
        do_req(1'b1, 3'b100, 32'h20, 32'h77, rd);
        do_req(1'b0, 3'b000, 32'hFFFF_FFFF, 32'd0, rd);
        do_req(1'b0, 3'b010, 32'hFFFF_FFFC, 32'd0, rd);
        // Range edges
        do_req(1'b0, 3'b000, 32'd498, 32'd0, rd);
        do_req(1'b0, 3'b000, 32'd499, 32'd0, rd);
        do_req(1'b0, 3'b010, 32'd492, 32'd0, rd);
        do_req(1'b0, 3'b010, 32'd496, 32'd0, rd);
        do_req(1'b1, 3'b001, 32'd496, 32'hBEEF, rd);
        do_req(1'b0, 3'b001, 32'd498, 32'd0, rd);

        // Reset during the write cycle of a store
        old = ref_mem[9'h40];
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h40; req_wdata = {24'd0, ~old};
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("mid_store_we", ram_write_enable, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_store_we_gated", ram_write_enable, 0);
        chk("mid_store_stall", stall, 0);
        @(negedge clk);
        chk("mid_store_no_resp", resp_valid, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_no_resp", resp_valid, 0);
        chk("mid_store_byte_kept", ram[9'h40], old);

        // Back-to-back loads with req_valid held high
        exp1 = model_load(3'b010, 32'h10);
        exp2 = model_load(3'b100, 32'h21);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk);
        #1 req_funct3 = 3'b100; req_addr = 32'h21;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("b2b_stall_a", stall, 1);
            chk("b2b_not_ready_a", req_ready, 0);
            chk("b2b_resp_a", resp_valid, (c == 3) ? 1 : 0);
            if (c == 3) chk("b2b_rdata_a", resp_rdata, exp1);
        end
        @(negedge clk);
        chk("b2b_ready_idle", req_ready, 1);
        chk("b2b_stall_gap", stall, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("b2b_stall_b", stall, 1);
            chk("b2b_resp_b", resp_valid, (c == 3) ? 1 : 0);
            if (c == 3) chk("b2b_rdata_b", resp_rdata, exp2);
        end
        @(negedge clk);
        chk("b2b_done_stall", stall, 0);

        // Random traffic mixing legal, misaligned, out-of-range and illegal requests
        for (int n = 0; n < 80; n++) begin
            st = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, MemBytes + 7));
                1:       a = 32'(MemBytes - $urandom_range(1, 6));
                2:       a = $urandom;
                default: a = 32'($urandom_range(0, MemBytes - 1)) & 32'hFFFF_FFFC;
            endcase
            do_req(st, 3'($urandom), a, $urandom, rd);
        end

        mism = 0;
        for (int i = 0; i < MemBytes; i++) if (ram[i] !== ref_mem[i]) mism++;
        chk("mem_image", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
